// File: rtl/m1_fill.sv
// ============================================================================
// Module   : m1_fill
// Brief    : Packs N-bit values into Tn-lane lines and writes them circularly
//            into the m1 line buffer, tracking line occupancy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module m1_fill #(
    parameter int N         = 16,
    parameter int Tn        = 16,
    parameter int NXTN      = N * Tn,
    parameter int ADDR      = 6,
    parameter int NUM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_release,
    output logic              o_wen,
    output logic [ADDR-1:0]   o_addr,
    output logic [NXTN-1:0]   o_data,
    output logic [ADDR:0]     o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int LANE_W = (Tn > 1) ? $clog2(Tn) : 1;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_nx;
    logic [ADDR-1:0]   wr_ptr;
    logic              accept;
    logic              line_done;
    logic              flush_go;
    logic              to_write;
    logic              cnt_inc;
    logic              cnt_dec;

    assign o_full  = (o_count == (ADDR+1)'(NUM_WORDS));
    assign o_empty = (o_count == '0);
    assign o_ready = (state == FILL) && !o_full;
    assign o_addr  = wr_ptr;

    always_comb begin
        accept    = i_valid && o_ready;
        line_done = accept && (lane == LANE_W'(Tn - 1));
        // A same-cycle accept counts as content, so flush at lane 0 still writes.
        flush_go  = (state == FILL) && i_flush && !o_full && ((lane != '0) || accept);
        to_write  = line_done || flush_go;
        cnt_inc   = (state == WRITE);
        cnt_dec   = i_release && (o_count != '0);

        state_nx = state;
        lane_nx  = lane;
        case (state)
            FILL: begin
                if (to_write) begin
                    state_nx = WRITE;
                    lane_nx  = '0;
                end else if (accept) begin
                    lane_nx  = lane + LANE_W'(1);
                end
            end
            WRITE: begin
                state_nx = FILL;
            end
            default: begin
                state_nx = FILL;
                lane_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            lane  <= '0;
        end else begin
            state <= state_nx;
            lane  <= lane_nx;
        end
    end

    // The line register clears on WRITE exit so flushed lines are zero-padded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
        end else if (state == WRITE) begin
            o_data <= '0;
        end else if (accept) begin
            o_data[int'(lane)*N +: N] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wen  <= 1'b1;
            wr_ptr <= '0;
        end else begin
            o_wen <= !to_write;
            if (state == WRITE) begin
                wr_ptr <= wr_ptr + ADDR'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   o_count <= o_count + (ADDR+1)'(1);
                2'b01:   o_count <= o_count - (ADDR+1)'(1);
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

`default_nettype wire
